// File: rtl/rx_sonar_7o1.sv
// 7O1 UART receiver for the sonar link, plus a parser for "CDU,cdu#" frames into BCD angle/distance.
// Optional RX_FRAME_TIMEOUT_EN: discard a partial frame after TIMEOUT_BITS idle bit periods.
module rx_sonar_7o1 #(
  parameter int         CLOCK_FREQ   = 50_000_000,
  parameter int         BAUD         = 115_200,
  parameter logic [6:0] SEP_CHAR     = 7'h2C,
  parameter logic [6:0] END_CHAR     = 7'h23,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [6:0]  dado_recebido,
  output logic        pronto_rx,
  output logic        erro_paridade,
  output logic [11:0] angulo,
  output logic [11:0] distancia,
  output logic        medida_valida,
  output logic        erro_quadro,
  output logic [3:0]  db_estado
);

  localparam int DIV  = CLOCK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    START   = 3'd1,
    DADOS   = 3'd2,
    STOP    = 3'd3,
    FINAL   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_q, stop_d;
  logic [6:0]    dado_q, dado_d;
  logic          pronto_q, pronto_d, perr_q, perr_d;
  logic [2:0]    idx_q, idx_d;
  logic [11:0]   ang_sh_q, ang_sh_d, dist_sh_q, dist_sh_d;
  logic [11:0]   ang_q, ang_d, dist_q, dist_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          is_digit, char_ok;
`ifdef RX_FRAME_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * DIV;
  logic [31:0]   idle_q, idle_d;
`endif

  // Byte layer: synchroniser, falling-edge detect and bit-sampling FSM.
  always_comb begin
    sync1_d  = entrada_serial;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    stop_d   = stop_q;
    dado_d   = dado_q;
    pronto_d = 1'b0;
    perr_d   = 1'b0;
    case (state_q)
      INICIAL: begin
        tick_d = '0;
        bit_d  = '0;
        if (prev_q && !sync2_q) state_d = START;
      end
      START: begin
        if (tick_q == CW'(HALF - 1)) begin
          tick_d  = '0;
          state_d = sync2_q ? INICIAL : DADOS;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DADOS: begin
        if (tick_q == CW'(DIV - 1)) begin
          tick_d  = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      STOP: begin
        if (tick_q == CW'(DIV - 1)) begin
          tick_d  = '0;
          stop_d  = sync2_q;
          state_d = FINAL;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      FINAL: begin
        dado_d = shift_q[6:0];
        // shift_q holds {parity, data}; odd parity means odd total ones.
        if (stop_q && (^shift_q)) pronto_d = 1'b1;
        else                      perr_d   = 1'b1;
        state_d = INICIAL;
      end
      default: state_d = INICIAL;
    endcase
  end

  // Frame layer: advances on each good character, resets on any error.
  always_comb begin
    idx_d     = idx_q;
    ang_sh_d  = ang_sh_q;
    dist_sh_d = dist_sh_q;
    ang_d     = ang_q;
    dist_d    = dist_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    is_digit  = (dado_q >= 7'h30) && (dado_q <= 7'h39);
    case (idx_q)
      3'd3:    char_ok = (dado_q == SEP_CHAR);
      3'd7:    char_ok = (dado_q == END_CHAR);
      default: char_ok = is_digit;
    endcase
`ifdef RX_FRAME_TIMEOUT_EN
    idle_d = (state_q == INICIAL && idx_q != 3'd0) ? idle_q + 32'd1 : 32'd0;
`endif
    if (perr_q) begin
      ferr_d = 1'b1;
      idx_d  = 3'd0;
    end else if (pronto_q) begin
      if (char_ok) begin
        case (idx_q)
          3'd0: ang_sh_d[11:8]  = dado_q[3:0];
          3'd1: ang_sh_d[7:4]   = dado_q[3:0];
          3'd2: ang_sh_d[3:0]   = dado_q[3:0];
          3'd4: dist_sh_d[11:8] = dado_q[3:0];
          3'd5: dist_sh_d[7:4]  = dado_q[3:0];
          3'd6: dist_sh_d[3:0]  = dado_q[3:0];
          default: ;
        endcase
        if (idx_q == 3'd7) begin
          ang_d   = ang_sh_q;
          dist_d  = dist_sh_q;
          valid_d = 1'b1;
          idx_d   = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        // A stray terminator just realigns to the next frame without complaint.
        idx_d  = 3'd0;
        ferr_d = (dado_q != END_CHAR);
      end
    end
`ifdef RX_FRAME_TIMEOUT_EN
    else if (state_q == INICIAL && idx_q != 3'd0 && idle_q >= 32'(TO_LIMIT - 1)) begin
      ferr_d = 1'b1;
      idx_d  = 3'd0;
      idle_d = 32'd0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= INICIAL;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      stop_q    <= 1'b0;
      dado_q    <= '0;
      pronto_q  <= 1'b0;
      perr_q    <= 1'b0;
      idx_q     <= '0;
      ang_sh_q  <= '0;
      dist_sh_q <= '0;
      ang_q     <= '0;
      dist_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef RX_FRAME_TIMEOUT_EN
      idle_q    <= '0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      stop_q    <= stop_d;
      dado_q    <= dado_d;
      pronto_q  <= pronto_d;
      perr_q    <= perr_d;
      idx_q     <= idx_d;
      ang_sh_q  <= ang_sh_d;
      dist_sh_q <= dist_sh_d;
      ang_q     <= ang_d;
      dist_q    <= dist_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef RX_FRAME_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  assign dado_recebido = dado_q;
  assign pronto_rx     = pronto_q;
  assign erro_paridade = perr_q;
  assign angulo        = ang_q;
  assign distancia     = dist_q;
  assign medida_valida = valid_q;
  assign erro_quadro   = ferr_q;
  assign db_estado     = {1'b0, state_q};

endmodule
